sccb_config: RTL and testbench

- Boot-time register configurator for the OV7670 sensor.
- Walks a synchronous register table of {reg_addr, value} entries and issues one SCCB 3-phase write (ID, register, data) per entry on SIO_C/SIO_D.
- Raises `cfg_done` when the table is finished. Camera capture control gates `work_en` on `cfg_done`.
- Sits beside the FIFO capture controller on the camera pixel clock domain.

---
 rtl/sccb_config.sv | 182 ++++++++++++++++++
 tb/tb_sccb_config.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_config.sv
// OV7670 boot configurator: walks a sync-ROM {reg,val} table, one SCCB 3-phase write per entry.
// Entry period 2 + 113*QDIV + GAP_CYCLES clk; pads registered, async reset forces idle bus.
module sccb_config #(
    parameter int          QDIV         = 100,
    parameter logic [7:0]  SLAVE_ID     = 8'h42,
    parameter int          GAP_CYCLES   = 400,
    parameter logic [15:0] DELAY_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_start,
    output logic [7:0]  tbl_addr,
    input  logic [15:0] tbl_data,
    output logic        sio_c,
    output logic        sio_d_out,
    output logic        sio_d_oe,
    input  logic        sio_d_in,
    output logic        busy,
    output logic        cfg_done,
    output logic        nack_err
);
    localparam int            QW         = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [QW-1:0] QLAST      = QW'(QDIV - 1);
    localparam logic [15:0]   GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0]   DELAY_LAST = DELAY_CYCLES - 16'd1;

    typedef enum logic [3:0] {IDLE, FETCH, DECODE, START, SHIFT, STOP, GAP, WAIT, DONE} state_t;

    state_t        state, state_nx;
    logic [QW-1:0] qcnt, qcnt_nx;
    logic [1:0]    phase, phase_nx;
    logic [4:0]    bitcnt, bitcnt_nx;
    logic [15:0]   dcnt, dcnt_nx;
    logic [26:0]   word, word_nx;
    logic [7:0]    addr_nx;
    logic          busy_nx, done_nx, nack_nx;
    logic          c_nx, d_nx, oe_nx;
    logic          qlast, xbit, adv;

    assign qlast = (qcnt == QLAST);
    assign xbit  = (bitcnt == 5'd8) || (bitcnt == 5'd17) || (bitcnt == 5'd26);

    always_comb begin
        state_nx  = state;
        qcnt_nx   = qlast ? '0 : qcnt + 1'b1;
        phase_nx  = phase;
        bitcnt_nx = bitcnt;
        dcnt_nx   = dcnt + 16'd1;
        word_nx   = word;
        addr_nx   = tbl_addr;
        busy_nx   = busy;
        done_nx   = cfg_done;
        nack_nx   = nack_err;
        adv       = 1'b0;

        case (state)
            IDLE: begin
                if (cfg_start) begin
                    addr_nx  = 8'd0;
                    busy_nx  = 1'b1;
                    done_nx  = 1'b0;
                    nack_nx  = 1'b0;
                    state_nx = FETCH;
                end
            end
            FETCH: state_nx = DECODE;
            DECODE: begin
                qcnt_nx  = '0;
                phase_nx = 2'd0;
                dcnt_nx  = 16'd0;
                if (tbl_data == 16'hFFFF) begin
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end else if (tbl_data == 16'hFFF0) begin
                    state_nx = WAIT;
                end else begin
                    // X positions hold 1 so a released bit reads as idle-high
                    word_nx  = {SLAVE_ID, 1'b1, tbl_data[15:8], 1'b1, tbl_data[7:0], 1'b1};
                    state_nx = START;
                end
            end
            START: begin
                if (qlast) begin
                    if (phase == 2'd1) begin
                        phase_nx  = 2'd0;
                        bitcnt_nx = 5'd0;
                        state_nx  = SHIFT;
                    end else begin
                        phase_nx = phase + 2'd1;
                    end
                end
            end
            SHIFT: begin
                if (phase == 2'd2 && qlast && xbit && sio_d_in)
                    nack_nx = 1'b1;
                if (qlast) begin
                    phase_nx = phase + 2'd1;
                    if (phase == 2'd3) begin
                        if (bitcnt == 5'd26) state_nx = STOP;
                        else                 bitcnt_nx = bitcnt + 5'd1;
                    end
                end
            end
            STOP: begin
                dcnt_nx = 16'd0;
                if (qlast) begin
                    if (phase == 2'd2) state_nx = GAP;
                    else               phase_nx = phase + 2'd1;
                end
            end
            GAP:  adv = (dcnt == GAP_LAST);
            WAIT: adv = (dcnt == DELAY_LAST);
            DONE: state_nx = DONE;
            default: state_nx = IDLE;
        endcase

        if (adv) begin
            if (tbl_addr == 8'hFF) begin
                busy_nx  = 1'b0;
                done_nx  = 1'b1;
                state_nx = DONE;
            end else begin
                addr_nx  = tbl_addr + 8'd1;
                state_nx = FETCH;
            end
        end

        // Pad values follow the next state so the registered pins line up with it
        c_nx  = 1'b1;
        d_nx  = 1'b1;
        oe_nx = 1'b1;
        case (state_nx)
            START: begin
                c_nx = (phase_nx == 2'd0);
                d_nx = 1'b0;
            end
            SHIFT: begin
                c_nx  = (phase_nx == 2'd1) || (phase_nx == 2'd2);
                d_nx  = word_nx[5'd26 - bitcnt_nx];
                oe_nx = !((bitcnt_nx == 5'd8) || (bitcnt_nx == 5'd17) || (bitcnt_nx == 5'd26));
            end
            STOP: begin
                c_nx = (phase_nx != 2'd0);
                d_nx = (phase_nx == 2'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            qcnt      <= '0;
            phase     <= 2'd0;
            bitcnt    <= 5'd0;
            dcnt      <= 16'd0;
            word      <= '0;
            tbl_addr  <= 8'd0;
            busy      <= 1'b0;
            cfg_done  <= 1'b0;
            nack_err  <= 1'b0;
            sio_c     <= 1'b1;
            sio_d_out <= 1'b1;
            sio_d_oe  <= 1'b1;
        end else begin
            state     <= state_nx;
            qcnt      <= qcnt_nx;
            phase     <= phase_nx;
            bitcnt    <= bitcnt_nx;
            dcnt      <= dcnt_nx;
            word      <= word_nx;
            tbl_addr  <= addr_nx;
            busy      <= busy_nx;
            cfg_done  <= done_nx;
            nack_err  <= nack_nx;
            sio_c     <= c_nx;
            sio_d_out <= d_nx;
            sio_d_oe  <= oe_nx;
        end
    end
endmodule

// File: tb/tb_sccb_config.sv
// Directed bench for sccb_config: sync-ROM model, SCCB bus decoder, hand-computed expectations.
module tb_sccb_config;
    localparam int Q = 2;
    localparam int G = 4;
    localparam int D = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_start = 1'b0;
    logic [7:0]  tbl_addr;
    logic [15:0] tbl_data = 16'hFFFF;
    logic        sio_c, sio_d_out, sio_d_oe, sio_d_in;
    logic        busy, cfg_done, nack_err;
    logic        slave_pull = 1'b0;
    logic [15:0] rom [256];

    always #5 clk = ~clk;
    always @(posedge clk) tbl_data <= rom[tbl_addr];
    assign sio_d_in = sio_d_oe ? sio_d_out : slave_pull;

    sccb_config #(.QDIV(Q), .SLAVE_ID(8'h42), .GAP_CYCLES(G), .DELAY_CYCLES(16'(D))) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .sio_c(sio_c), .sio_d_out(sio_d_out), .sio_d_oe(sio_d_oe), .sio_d_in(sio_d_in),
        .busy(busy), .cfg_done(cfg_done), .nack_err(nack_err)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bus decoder: each write is pushed as {framing_ok, byte0, byte1, byte2}
    logic        pc = 1'b1, pd = 1'b1, in_tx = 1'b0, rel_ok = 1'b0;
    int          cyc = 0, c_edges = 0, busy_cyc = 0, last_stop = 0, nb = 0;
    logic [26:0] sh = '0;
    logic [24:0] wr_q[$];
    int          gap_q[$];

    always @(negedge clk) begin
        cyc++;
        if (busy) busy_cyc++;
        if (!rst) begin
            in_tx = 1'b0;
        end else begin
            if (sio_c != pc) c_edges++;
            if (pc && sio_c && pd && !sio_d_out && sio_d_oe) begin
                in_tx  = 1'b1;
                nb     = 0;
                rel_ok = 1'b1;
                gap_q.push_back(cyc - last_stop);
            end else if (in_tx && !pc && sio_c && nb < 27) begin
                sh = {sh[25:0], (sio_d_oe ? sio_d_out : 1'b1)};
                if ((nb % 9 == 8) == sio_d_oe) rel_ok = 1'b0;
                nb++;
            end else if (in_tx && pc && sio_c && !pd && sio_d_out) begin
                wr_q.push_back({(nb == 27) && rel_ok, sh[26:19], sh[17:10], sh[8:1]});
                in_tx     = 1'b0;
                last_stop = cyc;
            end
        end
        pc = sio_c;
        pd = sio_d_out;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        while (!cfg_done && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, cfg_done, 1'b1);
    endtask

    int base_w, base_b, base_c, base_g;

    initial begin
        fill_rom();
        tick(2);
        check("rst_sio_c", sio_c, 1'b1);
        check("rst_sio_d", sio_d_out, 1'b1);
        check("rst_oe", sio_d_oe, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", cfg_done, 1'b0);
        check("rst_nack", nack_err, 1'b0);
        check("rst_addr", tbl_addr, 8'd0);
        rst = 1'b1;
        tick(1);

        // Single write then terminator
        rom[0] = 16'h1280;
        base_w = wr_q.size(); base_b = busy_cyc; base_c = c_edges;
        pulse_start();
        wait_done(1000, "t1_done");
        tick(2);
        check("t1_busy_cycles", busy_cyc - base_b, 2 + 113 * Q + G + 2);
        check("t1_addr", tbl_addr, 8'd1);
        check("t1_busy", busy, 1'b0);
        check("t1_nack", nack_err, 1'b0);
        check("t1_c_edges", c_edges - base_c, 56);
        check("t1_nwr", wr_q.size() - base_w, 1);
        if (wr_q.size() > base_w) check("t1_wr", wr_q[base_w], {1'b1, 24'h421280});

        // Terminator at entry 0, then cfg_start in DONE is ignored
        do_reset();
        fill_rom();
        base_c = c_edges;
        pulse_start();
        tick(1);
        check("t2_done_early", cfg_done, 1'b0);
        tick(1);
        check("t2_done", cfg_done, 1'b1);
        check("t2_busy", busy, 1'b0);
        rom[0] = 16'h1280;
        base_w = wr_q.size();
        pulse_start();
        tick(300);
        check("t2_ignore_nwr", wr_q.size() - base_w, 0);
        check("t2_c_edges", c_edges - base_c, 0);
        check("t2_done_hold", cfg_done, 1'b1);
        check("t2_busy_hold", busy, 1'b0);

        // Delay entry between two writes
        do_reset();
        fill_rom();
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1104;
        base_w = wr_q.size(); base_b = busy_cyc; base_g = gap_q.size();
        pulse_start();
        wait_done(2000, "t3_done");
        tick(2);
        check("t3_nwr", wr_q.size() - base_w, 2);
        if (wr_q.size() > base_w + 1) begin
            check("t3_wr0", wr_q[base_w], {1'b1, 24'h421280});
            check("t3_wr1", wr_q[base_w + 1], {1'b1, 24'h421104});
        end
        if (gap_q.size() > base_g + 1) check("t3_stop_to_start", gap_q[base_g + 1], Q + G + 4 + D);
        check("t3_busy_cycles", busy_cyc - base_b, 488);
        check("t3_addr", tbl_addr, 8'd3);

        // NACK on every X bit: flagged at the first one, write still completes
        do_reset();
        fill_rom();
        rom[0] = 16'h1280;
        slave_pull = 1'b1;
        base_w = wr_q.size();
        pulse_start();
        tick(75);
        check("t4_nack_pre", nack_err, 1'b0);
        tick(1);
        check("t4_nack_first_x", nack_err, 1'b1);
        wait_done(1000, "t4_done");
        tick(2);
        check("t4_nack_sticky", nack_err, 1'b1);
        check("t4_nwr", wr_q.size() - base_w, 1);
        if (wr_q.size() > base_w) check("t4_wr", wr_q[base_w], {1'b1, 24'h421280});
        slave_pull = 1'b0;

        // Reset in the middle of byte 2 (bit 10, phase 0)
        do_reset();
        fill_rom();
        rom[0] = 16'h1280;
        pulse_start();
        tick(86);
        check("t5_pre_c", sio_c, 1'b0);
        check("t5_pre_d", sio_d_out, 1'b0);
        check("t5_pre_busy", busy, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("t5_rst_c", sio_c, 1'b1);
        check("t5_rst_d", sio_d_out, 1'b1);
        check("t5_rst_oe", sio_d_oe, 1'b1);
        check("t5_rst_busy", busy, 1'b0);
        tick(2);
        rst = 1'b1;
        tick(1);
        base_c = c_edges; base_w = wr_q.size();
        tick(300);
        check("t5_quiet_c", c_edges - base_c, 0);
        check("t5_quiet_nwr", wr_q.size() - base_w, 0);
        check("t5_quiet_busy", busy, 1'b0);

        // Full 256-entry table, no terminator, restarts ignored mid-walk
        do_reset();
        for (int i = 0; i < 256; i++) rom[i] = {8'(i), 8'(i) ^ 8'h5A};
        base_w = wr_q.size(); base_b = busy_cyc;
        pulse_start();
        tick(5000);
        pulse_start();
        tick(20000);
        pulse_start();
        wait_done(60000, "t6_done");
        tick(2);
        check("t6_nwr", wr_q.size() - base_w, 256);
        check("t6_addr", tbl_addr, 8'hFF);
        check("t6_busy", busy, 1'b0);
        check("t6_busy_cycles", busy_cyc - base_b, 256 * (2 + 113 * Q + G));
        for (int i = 0; i < 256; i++) begin
            if (wr_q.size() > base_w + i)
                check($sformatf("t6_wr%0d", i), wr_q[base_w + i], {1'b1, 8'h42, 8'(i), 8'(i) ^ 8'h5A});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
